// File: rtl/arb_pkg.sv
// Shared constants, action encodings and FSM state type for the trade-report framer.
package arb_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;
  localparam logic [7:0] DEFAULT_FOOTER = 8'h55;

  localparam logic [7:0] ACT_NONE  = 8'h00;
  localparam logic [7:0] ACT_BUY_A = 8'h01;
  localparam logic [7:0] ACT_BUY_B = 8'h02;

  // The header byte is issued on the IDLE exit, so no separate header state is needed.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTION,
    ST_PROFIT,
    ST_CHECK,
    ST_FOOTER
  } frame_state_t;

  function automatic int unsigned frame_len(input int unsigned profit_bytes, input bit checksum_en);
    return 3 + profit_bytes + (checksum_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/arb_report_fifo.sv
// Small first-word-fall-through report queue; dout always shows the head entry.
module arb_report_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == LEVEL_FULL);
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LEVEL_ONE;
        2'b01:   level_reg <= level_reg - LEVEL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/trade_report_framer.sv
// Queues trade reports and serialises each as header/action/profit/checksum/footer bytes for the UART.
module trade_report_framer
  import arb_pkg::*;
#(
  parameter int          PROFIT_BYTES = 2,
  parameter int          FIFO_DEPTH   = 4,
  parameter bit          CHECKSUM_EN  = 1'b1,
  parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER,
  parameter logic [7:0]  FOOTER_BYTE  = DEFAULT_FOOTER
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            report_valid,
  input  logic [7:0]                      trade_action,
  input  logic [8*PROFIT_BYTES-1:0]       profit,
  input  logic                            tx_busy,
  output logic                            tx_en,
  output logic [7:0]                      tx_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic [7:0]                      drop_count
);

  localparam int PW = 8 * PROFIT_BYTES;
  localparam int RW = 8 + PW;
  localparam int IW = (PROFIT_BYTES > 1) ? $clog2(PROFIT_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PROFIT_BYTES - 1);

  frame_state_t      state_reg;
  logic              tx_en_reg;
  logic [7:0]        tx_data_reg;
  logic [RW-1:0]     frame_reg;
  logic [IW-1:0]     idx_reg;
  logic              overflow_reg;
  logic [7:0]        drop_count_reg;

  logic              report_ok;
  logic              push;
  logic              pop;
  logic              drop;
  logic              issue_ok;
  logic [RW-1:0]     fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        frame_action;
  logic [PW-1:0]     frame_profit;
  logic [7:0]        profit_byte;
  logic [7:0]        chk_byte;

  assign report_ok = report_valid && (trade_action != ACT_NONE);
  assign push      = report_ok && !fifo_full;
  assign drop      = report_ok && fifo_full;
  assign issue_ok  = !tx_busy && !tx_en_reg;
  assign pop       = (state_reg == ST_IDLE) && !fifo_empty && issue_ok;

  arb_report_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({trade_action, profit}),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign frame_action = frame_reg[RW-1 -: 8];
  assign frame_profit = frame_reg[PW-1:0];
  assign profit_byte  = frame_profit[{idx_reg, 3'b000} +: 8];

  always_comb begin
    chk_byte = frame_action;
    for (int i = 0; i < PROFIT_BYTES; i++) chk_byte = chk_byte ^ frame_profit[8*i +: 8];
  end

  // Every state waits for the issue window, so strobes are never back to back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      tx_en_reg   <= 1'b0;
      tx_data_reg <= 8'h00;
      frame_reg   <= '0;
      idx_reg     <= '0;
    end else begin
      tx_en_reg   <= 1'b0;
      tx_data_reg <= 8'h00;
      if (issue_ok) begin
        case (state_reg)
          ST_IDLE: begin
            if (!fifo_empty) begin
              frame_reg   <= fifo_dout;
              tx_en_reg   <= 1'b1;
              tx_data_reg <= HEADER_BYTE;
              state_reg   <= ST_ACTION;
            end
          end
          ST_ACTION: begin
            tx_en_reg   <= 1'b1;
            tx_data_reg <= frame_action;
            idx_reg     <= LAST_IDX;
            state_reg   <= ST_PROFIT;
          end
          ST_PROFIT: begin
            tx_en_reg   <= 1'b1;
            tx_data_reg <= profit_byte;
            if (idx_reg == '0) state_reg <= CHECKSUM_EN ? ST_CHECK : ST_FOOTER;
            else               idx_reg   <= idx_reg - 1'b1;
          end
          ST_CHECK: begin
            tx_en_reg   <= 1'b1;
            tx_data_reg <= chk_byte;
            state_reg   <= ST_FOOTER;
          end
          ST_FOOTER: begin
            tx_en_reg   <= 1'b1;
            tx_data_reg <= FOOTER_BYTE;
            state_reg   <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'h00;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'h01;
    end
  end

  assign tx_en      = tx_en_reg;
  assign tx_data    = tx_data_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_trade_report_framer.sv
// Cycle-level check of the framer against a queue-based byte-stream model, plus directed literal cases.
module tb_trade_report_framer;
  import arb_pkg::*;

  localparam int PB    = 2;
  localparam int DEPTH = 4;
  localparam bit CK    = 1'b1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic            report_valid = 1'b0;
  logic [7:0]      trade_action = 8'h00;
  logic [8*PB-1:0] profit       = '0;
  logic            tx_busy      = 1'b0;
  logic            tx_en;
  logic [7:0]      tx_data;
  logic [LW-1:0]   fifo_level;
  logic            overflow;
  logic [7:0]      drop_count;

  logic            report_valid4 = 1'b0;
  logic [7:0]      trade_action4 = 8'h00;
  logic [31:0]     profit4       = '0;
  logic            tx_busy4      = 1'b0;
  logic            tx_en4;
  logic [7:0]      tx_data4;
  logic [2:0]      fifo_level4;
  logic            overflow4;
  logic [7:0]      drop_count4;

  trade_report_framer #(.PROFIT_BYTES(PB), .FIFO_DEPTH(DEPTH), .CHECKSUM_EN(CK)) dut (
    .clk(clk), .rst(rst), .report_valid(report_valid), .trade_action(trade_action),
    .profit(profit), .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
  );

  trade_report_framer #(.PROFIT_BYTES(4), .FIFO_DEPTH(4), .CHECKSUM_EN(1'b0)) dut4 (
    .clk(clk), .rst(rst), .report_valid(report_valid4), .trade_action(trade_action4),
    .profit(profit4), .tx_busy(tx_busy4), .tx_en(tx_en4), .tx_data(tx_data4),
    .fifo_level(fifo_level4), .overflow(overflow4), .drop_count(drop_count4)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: pending reports, remaining bytes of the frame on the wire, expected outputs.
  logic [8*PB+7:0] m_q[$];
  logic [7:0]      m_fb[$];
  logic            m_en    = 1'b0;
  logic [7:0]      m_data  = 8'h00;
  logic            m_ovf   = 1'b0;
  logic [7:0]      m_drops = 8'h00;

  logic [7:0] log_q[$];
  logic [7:0] log4_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit              ok;
    int              lvl;
    logic [8*PB+7:0] r;
    logic [8*PB-1:0] p;
    logic [7:0]      chk;
    logic            nen;
    logic [7:0]      nd;
    if (!rst) begin
      m_q.delete();
      m_fb.delete();
      m_en = 1'b0; m_data = 8'h00; m_ovf = 1'b0; m_drops = 8'h00;
    end else begin
      ok  = !tx_busy && !m_en;
      lvl = m_q.size();
      nen = 1'b0; nd = 8'h00;
      if (ok) begin
        if (m_fb.size() > 0) begin
          nen = 1'b1; nd = m_fb.pop_front();
        end else if (m_q.size() > 0) begin
          r   = m_q.pop_front();
          p   = r[8*PB-1:0];
          chk = r[8*PB+7 -: 8];
          m_fb.push_back(r[8*PB+7 -: 8]);
          for (int i = PB-1; i >= 0; i--) begin
            m_fb.push_back(p[8*i +: 8]);
            chk = chk ^ p[8*i +: 8];
          end
          if (CK) m_fb.push_back(chk);
          m_fb.push_back(DEFAULT_FOOTER);
          nen = 1'b1; nd = DEFAULT_HEADER;
        end
      end
      if (report_valid && trade_action != ACT_NONE) begin
        if (lvl == DEPTH) begin
          m_ovf = 1'b1;
          if (m_drops != 8'hFF) m_drops = m_drops + 8'h01;
        end else begin
          m_q.push_back({trade_action, profit});
        end
      end
      m_en = nen; m_data = nd;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (tx_en)  log_q.push_back(tx_data);
    if (tx_en4) log4_q.push_back(tx_data4);
    check("tx_en",      32'(tx_en),      32'(m_en));
    check("tx_data",    32'(tx_data),    32'(m_data));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drops));
  end

  task automatic pulse(input logic [7:0] a, input logic [8*PB-1:0] p);
    report_valid = 1'b1; trade_action = a; profit = p;
    @(negedge clk);
    report_valid = 1'b0; trade_action = 8'h00; profit = '0;
  endtask

  task automatic wait_log(input bit second, input int n, input int budget, input string name);
    int c = 0;
    while (((second ? log4_q.size() : log_q.size()) < n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check({name, "_bytes_seen"}, 32'(second ? log4_q.size() : log_q.size()), 32'(n));
  endtask

  task automatic check_log(input bit second, input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < (second ? log4_q.size() : log_q.size()))
        check($sformatf("%s_byte%0d", name, i), 32'(second ? log4_q[i] : log_q[i]), 32'(exp_q[i]));
      else
        check($sformatf("%s_byte%0d_missing", name, i), 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en",      32'(tx_en),      32'h0);
    check("rst_tx_data",    32'(tx_data),    32'h0);
    check("rst_fifo_level", 32'(fifo_level), 32'h0);
    check("rst_overflow",   32'(overflow),   32'h0);
    check("rst_drop_count", 32'(drop_count), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single report on both configurations; header two cycles after the strobe.
    report_valid  = 1'b1; trade_action  = ACT_BUY_A; profit  = 16'h1234;
    report_valid4 = 1'b1; trade_action4 = ACT_BUY_B; profit4 = 32'hDEADBEEF;
    @(negedge clk);
    report_valid  = 1'b0; trade_action  = 8'h00; profit  = '0;
    report_valid4 = 1'b0; trade_action4 = 8'h00; profit4 = '0;
    check("lat_no_hdr_yet", 32'(tx_en), 32'h0);
    check("lat_level1",     32'(fifo_level), 32'h1);
    @(negedge clk);
    check("lat_hdr_en",   32'(tx_en),   32'h1);
    check("lat_hdr_byte", 32'(tx_data), 32'hAA);
    wait_log(1'b0, frame_len(PB, CK), 100, "single");
    exp_q = '{8'hAA, 8'h01, 8'h12, 8'h34, 8'h27, 8'h55};
    check_log(1'b0, "single");
    wait_log(1'b1, frame_len(4, 1'b0), 100, "pb4");
    exp_q = '{8'hAA, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
    check_log(1'b1, "pb4");
    repeat (10) @(negedge clk);
    check("pb4_no_extra", 32'(log4_q.size()), 32'd7);

    // No-trade reports are ignored entirely.
    log_q.delete();
    pulse(ACT_NONE, 16'hFFFF);
    check("none_level", 32'(fifo_level), 32'h0);
    repeat (10) @(negedge clk);
    check("none_no_frame", 32'(log_q.size()), 32'h0);
    check("none_no_drop",  32'(drop_count),   32'h0);

    // Three queued while busy, then drained in arrival order.
    tx_busy = 1'b1;
    pulse(ACT_BUY_A, 16'h0102);
    pulse(ACT_BUY_B, 16'hA5F0);
    pulse(ACT_BUY_A, 16'hFFFF);
    repeat (1000) @(negedge clk);
    check("b2b_level",    32'(fifo_level),   32'h3);
    check("b2b_overflow", 32'(overflow),     32'h0);
    check("b2b_silent",   32'(log_q.size()), 32'h0);
    tx_busy = 1'b0;
    wait_log(1'b0, 18, 200, "b2b");
    exp_q = '{8'hAA, 8'h01, 8'h01, 8'h02, 8'h02, 8'h55,
              8'hAA, 8'h02, 8'hA5, 8'hF0, 8'h57, 8'h55,
              8'hAA, 8'h01, 8'hFF, 8'hFF, 8'h01, 8'h55};
    check_log(1'b0, "b2b");

    // Overflow: one frame in flight, four queued, sixth dropped, then saturation.
    log_q.delete();
    pulse(ACT_BUY_A, 16'h0001);
    wait_log(1'b0, 1, 20, "ovf_hdr");
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) pulse(ACT_BUY_B, 16'(16'h0010 + i));
    check("ovf_level", 32'(fifo_level), 32'h4);
    check("ovf_flag",  32'(overflow),   32'h1);
    check("ovf_drops", 32'(drop_count), 32'h1);
    for (int i = 0; i < 300; i++) pulse(ACT_BUY_A, 16'(i));
    check("sat_drops", 32'(drop_count), 32'hFF);
    check("sat_level", 32'(fifo_level), 32'h4);
    tx_busy = 1'b0;
    wait_log(1'b0, 30, 400, "ovf_drain");

    // Reset after the action byte aborts the frame; a fresh frame follows.
    log_q.delete();
    pulse(ACT_BUY_B, 16'h0BAD);
    wait_log(1'b0, 2, 20, "abort_pre");
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx_en", 32'(tx_en),      32'h0);
    check("abort_level", 32'(fifo_level), 32'h0);
    check("abort_ovf",   32'(overflow),   32'h0);
    check("abort_drops", 32'(drop_count), 32'h0);
    @(negedge clk);
    check("abort_tx_en2", 32'(tx_en), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    log_q.delete();
    pulse(ACT_BUY_A, 16'h00C3);
    wait_log(1'b0, 6, 50, "fresh");
    exp_q = '{8'hAA, 8'h01, 8'h00, 8'hC3, 8'hC2, 8'h55};
    check_log(1'b0, "fresh");

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      report_valid = ($urandom_range(3) == 0);
      trade_action = 8'($urandom_range(3));
      profit       = 16'($urandom);
      tx_busy      = ($urandom_range(2) == 0);
      @(negedge clk);
    end
    report_valid = 1'b0; trade_action = 8'h00; profit = '0; tx_busy = 1'b0;
    repeat (80) @(negedge clk);
    check("drained_level", 32'(fifo_level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
